// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared matrix geometry, colour codes and PIX_IN field positions.
package led_matrix_pkg;
  localparam int MATRIX_W = 8;
  localparam int MATRIX_H = 16;
  typedef logic [1:0] colour_t;
  localparam colour_t COL_NONE = 2'b00;
  localparam colour_t COL_BAR  = 2'b10;
  localparam colour_t COL_BALL = 2'b01;
  localparam colour_t COL_BOTH = 2'b11;
  localparam int PIX_COL_HI = 9;
  localparam int PIX_COL_LO = 8;
  localparam int PIX_RSV    = 7;
  localparam int PIX_Y_HI   = 6;
  localparam int PIX_Y_LO   = 3;
  localparam int PIX_X_HI   = 2;
  localparam int PIX_X_LO   = 0;
endpackage

// File: rtl/led_matrix_scan_decoder_led_pixel_store.sv
// led_pixel_store: 128-pixel colour/age store with capture, frame-end aging and row read-out.
module led_pixel_store
  import led_matrix_pkg::*;
#(
  parameter int HOLD_FRAMES = 3
) (
  input  logic                         CLK,
  input  logic                         RSTn,
  input  logic [9:0]                   PIX_IN,
  input  logic                         frame_end,
  input  logic [3:0]                   row_sel,
  output colour_t [MATRIX_W-1:0]       row_colour,
  output logic    [MATRIX_W-1:0]       row_lit
);
  localparam int N = MATRIX_W * MATRIX_H;
  colour_t    colour [N];
  logic [2:0] age    [N];
  logic       capture;
  logic [6:0] cap_idx;
  assign capture = PIX_IN[PIX_COL_HI:PIX_COL_LO] != COL_NONE && !PIX_IN[PIX_RSV];
  assign cap_idx = {PIX_IN[PIX_Y_HI:PIX_Y_LO], PIX_IN[PIX_X_HI:PIX_X_LO]};
  // capture takes priority over the frame-end decrement on the same pixel
  always_ff @(posedge CLK) begin
    for (int i = 0; i < N; i++) begin
      if (!RSTn) begin
        colour[i] <= COL_NONE;
        age[i]    <= '0;
      end else if (capture && cap_idx == 7'(i)) begin
        colour[i] <= PIX_IN[PIX_COL_HI:PIX_COL_LO];
        age[i]    <= 3'(HOLD_FRAMES);
      end else if (frame_end && age[i] != '0) begin
        age[i] <= age[i] - 3'd1;
      end
    end
  end
  always_comb begin
    row_colour = '0;
    row_lit    = '0;
    for (int x = 0; x < MATRIX_W; x++) begin
      row_colour[x] = colour[{row_sel, 3'(x)}];
      row_lit[x]    = age[{row_sel, 3'(x)}] != '0;
    end
  end
endmodule

// File: rtl/led_matrix_scan_decoder.sv
// led_matrix_scan_decoder: pixel-command store scanned out to a 16x8 bicolour matrix; LED_SCAN_BLANK_EN adds a per-row blank interval.
module led_matrix_scan_decoder
  import led_matrix_pkg::*;
#(
  parameter int ROW_DWELL    = 2000,
  parameter int HOLD_FRAMES  = 3,
  parameter int BLANK_CYCLES = 50
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [9:0]  PIX_IN,
  output logic [15:0] ROWout,
  output logic [7:0]  COLRout,
  output logic [7:0]  COLGout,
  output logic        FRAME_TICK
);
  localparam logic [15:0] D_LAST = 16'(ROW_DWELL - 1);
  if (ROW_DWELL < 2 || ROW_DWELL > 65535 || HOLD_FRAMES < 1 || HOLD_FRAMES > 7 ||
      BLANK_CYCLES < 0 || BLANK_CYCLES > 65535) begin : g_bad_params
    $error("led_matrix_scan_decoder: parameter out of range");
  end
  logic [3:0]                r;
  logic [15:0]               d;
  logic                      frame_end;
  logic                      blank;
  colour_t [MATRIX_W-1:0]    row_colour;
  logic    [MATRIX_W-1:0]    row_lit;
  logic    [MATRIX_W-1:0]    red;
  logic    [MATRIX_W-1:0]    green;
  assign frame_end = r == 4'(MATRIX_H - 1) && d == D_LAST;
`ifdef LED_SCAN_BLANK_EN
  if (BLANK_CYCLES >= ROW_DWELL) begin : g_bad_blank
    $error("led_matrix_scan_decoder: BLANK_CYCLES must be below ROW_DWELL");
  end
  assign blank = d < 16'(BLANK_CYCLES);
`else
  assign blank = 1'b0;
`endif
  led_pixel_store #(.HOLD_FRAMES(HOLD_FRAMES)) u_store (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .PIX_IN     (PIX_IN),
    .frame_end  (frame_end),
    .row_sel    (r),
    .row_colour (row_colour),
    .row_lit    (row_lit)
  );
  always_comb begin
    red   = '0;
    green = '0;
    for (int x = 0; x < MATRIX_W; x++) begin
      red[x]   = row_lit[x] && |(row_colour[x] & COL_BAR);
      green[x] = row_lit[x] && |(row_colour[x] & COL_BALL);
    end
  end
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r          <= '0;
      d          <= '0;
      ROWout     <= '0;
      COLRout    <= '0;
      COLGout    <= '0;
      FRAME_TICK <= 1'b0;
    end else begin
      d          <= d == D_LAST ? '0 : d + 16'd1;
      r          <= d == D_LAST ? r + 4'd1 : r;
      ROWout     <= blank ? '0 : 16'(1) << r;
      COLRout    <= blank ? '0 : red;
      COLGout    <= blank ? '0 : green;
      FRAME_TICK <= frame_end;
    end
  end
endmodule
